// File: rtl/csi_pkg.sv
// Shared CSI-2 receive definitions: handler states, header layout
// and the byte-lane mask used on the final payload word.
package csi_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        WAIT_HDR = 3'd1,
        LONG     = 3'd2,
        EOP      = 3'd3,
        GAP      = 3'd4
    } state_t;

    // Data types above this value carry a payload
    localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

    typedef struct packed {
        logic [7:0]  ecc;
        logic [15:0] wc;
        logic [1:0]  vc;
        logic [5:0]  dt;
    } csi_hdr_t;

    function automatic logic [3:0] last_byte_mask(input logic [1:0] rem);
        logic [3:0] mask;
        mask = 4'b1111;
        unique case (rem)
            2'd0: mask = 4'b1111;
            2'd1: mask = 4'b0001;
            2'd2: mask = 4'b0011;
            2'd3: mask = 4'b0111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/csi_rx_packet_handler_mvc_if.sv
// Word stream from the combiner and tagged payload stream to the consumer.
// data_frame is reserved and only carried on the source side.
interface csi_rx_packet_handler_mvc_if;
    logic [31:0] data;
    logic        data_enable;
    logic        data_frame;
    logic [31:0] payload;
    logic        payload_enable;
    logic        payload_frame;
    logic [1:0]  payload_vc;
    logic        payload_last;
    logic [3:0]  payload_bytes;

    modport master (
        input  data, data_enable,
        output payload, payload_enable, payload_frame,
        output payload_vc, payload_last, payload_bytes
    );

    modport slave (
        output data, data_enable, data_frame,
        input  payload, payload_enable, payload_frame,
        input  payload_vc, payload_last, payload_bytes
    );
endinterface

// File: rtl/csi_header_ecc.sv
// CSI-2 packet header ECC generator (6 parity bits over 24 header bits).
module csi_header_ecc (
    input  logic [23:0] data,
    output logic [7:0]  ecc
);
    localparam logic [23:0] P0 = 24'hF12CB7;
    localparam logic [23:0] P1 = 24'hF2555B;
    localparam logic [23:0] P2 = 24'h749A6D;
    localparam logic [23:0] P3 = 24'hB8E38E;
    localparam logic [23:0] P4 = 24'hDF03F0;
    localparam logic [23:0] P5 = 24'hEFFC00;

    assign ecc = {2'b00,
                  ^(data & P5), ^(data & P4), ^(data & P3),
                  ^(data & P2), ^(data & P1), ^(data & P0)};
endmodule

// File: rtl/csi_rx_packet_handler_mvc.sv
// Multi-VC CSI-2 packet handler: header decode, per-VC frame/line
// tracking and long-packet payload extraction with error pulses.
module csi_rx_packet_handler_mvc
    import csi_pkg::*;
#(
    parameter logic [3:0]  VC_MASK  = 4'b0001,
    parameter logic [5:0]  FS_DT    = 6'h00,
    parameter logic [5:0]  FE_DT    = 6'h01,
    parameter logic [5:0]  VIDEO_DT = 6'h2A,
    parameter logic [15:0] MAX_LEN  = 16'd8192
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    csi_rx_packet_handler_mvc_if.master bus,
    input  logic       lp_detect,
    output logic       sync_wait,
    output logic       packet_done,
    output logic [3:0] vsync,
    output logic [3:0] in_frame,
    output logic [3:0] in_line,
    output logic       ecc_err,
    output logic       timeout_err,
    output logic       trunc_err
);

    state_t      state;
    state_t      state_nxt;
    csi_hdr_t    hdr;
    logic [7:0]  ecc_calc;
    logic [15:0] pkt_len;
    logic [16:0] bytes_read;
    logic [16:0] br_next;
    logic [1:0]  cur_vc;
    logic        ecc_ok;
    logic        vc_ok;
    logic        dt_ok;
    logic        hdr_valid;
    logic        hdr_long;
    logic        len_hit;
    logic        max_hit;
    logic        is_last;
    logic        hdr_take;
    logic        word_take;

    csi_header_ecc u_ecc (
        .data (bus.data[23:0]),
        .ecc  (ecc_calc)
    );

    assign hdr       = bus.data;
    assign ecc_ok    = (hdr.ecc == ecc_calc);
    assign vc_ok     = VC_MASK[hdr.vc];
    assign dt_ok     = (hdr.dt == FS_DT) || (hdr.dt == FE_DT)
                    || (hdr.dt == VIDEO_DT);
    assign hdr_valid = vc_ok && dt_ok && ecc_ok;
    assign hdr_long  = hdr_valid && (hdr.dt > SHORT_DT_MAX)
                    && (hdr.wc != 16'd0);

    // 17-bit count so the +4 never wraps against a 16-bit limit
    assign br_next = bytes_read + 17'd4;
    assign len_hit = br_next >= {1'b0, pkt_len};
    assign max_hit = br_next >= {1'b0, MAX_LEN};
    assign is_last = len_hit || max_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (lp_detect) begin
            state_nxt = INIT;
        end else begin
            unique case (state)
                INIT:     state_nxt = WAIT_HDR;
                WAIT_HDR: if (bus.data_enable)
                              state_nxt = hdr_long ? LONG : EOP;
                LONG:     if (bus.data_enable && is_last)
                              state_nxt = EOP;
                EOP:      state_nxt = GAP;
                GAP:      state_nxt = WAIT_HDR;
                default:  state_nxt = INIT;
            endcase
        end
    end

    always_comb begin
        sync_wait   = (state == WAIT_HDR);
        packet_done = (state == EOP) || lp_detect;
        hdr_take    = (state == WAIT_HDR) && bus.data_enable && !lp_detect;
        word_take   = (state == LONG) && bus.data_enable;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_len            <= '0;
            bytes_read         <= '0;
            cur_vc             <= '0;
            bus.payload        <= '0;
            bus.payload_enable <= 1'b0;
            bus.payload_frame  <= 1'b0;
            bus.payload_vc     <= '0;
            bus.payload_last   <= 1'b0;
            bus.payload_bytes  <= '0;
            vsync              <= '0;
            in_frame           <= '0;
            in_line            <= '0;
            ecc_err            <= 1'b0;
            timeout_err        <= 1'b0;
            trunc_err          <= 1'b0;
        end else if (enable) begin
            bus.payload_enable <= word_take;
            bus.payload_last   <= word_take && is_last;
            bus.payload_frame  <= (state == LONG);
            vsync              <= '0;
            ecc_err            <= 1'b0;
            timeout_err        <= word_take && !len_hit && max_hit;
            // A final word landing with lp_detect is a clean end, not a cut
            trunc_err          <= (state == LONG) && lp_detect
                               && !(word_take && is_last);
            if (word_take) begin
                bus.payload       <= bus.data;
                bus.payload_vc    <= cur_vc;
                bus.payload_bytes <= is_last ? last_byte_mask(pkt_len[1:0])
                                             : 4'b1111;
                if (is_last) begin
                    in_line[cur_vc] <= 1'b0;
                end else begin
                    bytes_read <= br_next;
                end
            end
            if (lp_detect) begin
                in_line[cur_vc] <= 1'b0;
            end
            if (hdr_take) begin
                ecc_err    <= !ecc_ok;
                bytes_read <= '0;
                if (vc_ok) begin
                    pkt_len <= hdr.wc;
                    cur_vc  <= hdr.vc;
                end
                if (hdr_valid) begin
                    unique case (1'b1)
                        (hdr.dt == FS_DT): begin
                            in_frame[hdr.vc] <= 1'b1;
                            vsync            <= 4'b0001 << hdr.vc;
                        end
                        (hdr.dt == FE_DT):    in_frame[hdr.vc] <= 1'b0;
                        (hdr.dt == VIDEO_DT): in_line[hdr.vc]  <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
